// File: rtl/iir_coef_ctrl_if.sv
// Coefficient write port for iir_coef_ctrl: valid/ready handshake carrying section, index and data.
interface iir_coef_ctrl_if #(
  parameter int unsigned SEC_W = 2
) ();
  logic             wr_valid;
  logic             wr_ready;
  logic [SEC_W-1:0] wr_sec;
  logic [2:0]       wr_idx;
  logic [15:0]      wr_data;

  modport master (output wr_valid, output wr_sec, output wr_idx, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_sec, input wr_idx, input wr_data, output wr_ready);
endinterface

// File: rtl/iir_coef_ctrl.sv
// Shadow/active coefficient banks for an N_SEC biquad cascade with tick-aligned atomic commit.
// Optional per-section flush pulses on commit are enabled with `define IIR_COEF_FLUSH_EN.
module iir_coef_ctrl #(
  parameter int unsigned       N_SEC  = 3,
  parameter int unsigned       SEC_W  = 2,
  parameter logic signed [15:0] B0_RST = 16'sh4000
) (
  input  logic                   clk,
  input  logic                   rst,
  iir_coef_ctrl_if.slave         wr,
  input  logic                   commit_req,
  output logic                   commit_ack,
  output logic                   commit_nak,
  input  logic                   sample_tick,
  output logic                   err,
  input  logic                   err_clr,
  output logic                   busy,
  output logic [N_SEC*16-1:0]    coef_b0,
  output logic [N_SEC*16-1:0]    coef_b1,
  output logic [N_SEC*16-1:0]    coef_b2,
  output logic [N_SEC*16-1:0]    coef_a1,
  output logic [N_SEC*16-1:0]    coef_a2
`ifdef IIR_COEF_FLUSH_EN
  ,
  output logic [N_SEC-1:0]       sec_flush
`endif
);

  localparam int unsigned NCOEF = 5;

  typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;

  state_t      state;
  logic [15:0] shadow [N_SEC][NCOEF];
  logic [15:0] active [N_SEC][NCOEF];
`ifdef IIR_COEF_FLUSH_EN
  logic [N_SEC-1:0] dirty;
`endif

  logic wr_acc;
  logic wr_ok;
  logic wr_bad;
  logic commit_go;

  always_comb begin
    wr_acc    = wr.wr_valid & wr.wr_ready;
    wr_ok     = wr_acc & (32'(wr.wr_sec) < N_SEC) & (wr.wr_idx <= 3'd4);
    wr_bad    = wr_acc & ~wr_ok;
    // busy stays up through the ack cycle, so a request there is ignored
    commit_go = (state == IDLE) & ~busy & commit_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      err         <= 1'b0;
      busy        <= 1'b0;
      commit_ack  <= 1'b0;
      commit_nak  <= 1'b0;
      wr.wr_ready <= 1'b0;
      for (int s = 0; s < N_SEC; s++) begin
        for (int c = 0; c < NCOEF; c++) begin
          shadow[s][c] <= (c == 0) ? B0_RST : 16'h0000;
          active[s][c] <= (c == 0) ? B0_RST : 16'h0000;
        end
      end
`ifdef IIR_COEF_FLUSH_EN
      dirty     <= '0;
      sec_flush <= '0;
`endif
    end else begin
      commit_ack <= 1'b0;
      commit_nak <= 1'b0;
`ifdef IIR_COEF_FLUSH_EN
      sec_flush  <= '0;
`endif

      if (wr_bad)       err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      for (int s = 0; s < N_SEC; s++) begin
        for (int c = 0; c < NCOEF; c++) begin
          if (wr_ok && wr.wr_sec == SEC_W'(s) && wr.wr_idx == 3'(c))
            shadow[s][c] <= wr.wr_data;
        end
`ifdef IIR_COEF_FLUSH_EN
        if (wr_ok && wr.wr_sec == SEC_W'(s)) dirty[s] <= 1'b1;
`endif
      end

      case (state)
        IDLE: begin
          busy        <= 1'b0;
          wr.wr_ready <= 1'b1;
          // a bad write in the same cycle as the request refuses the commit
          if (commit_go) begin
            if (err || wr_bad) begin
              commit_nak <= 1'b1;
            end else begin
              state       <= PEND;
              busy        <= 1'b1;
              wr.wr_ready <= 1'b0;
            end
          end
        end
        PEND: begin
          if (sample_tick) state <= APPLY;
        end
        APPLY: begin
          state       <= IDLE;
          commit_ack  <= 1'b1;
          wr.wr_ready <= 1'b1;
          for (int s = 0; s < N_SEC; s++) begin
            for (int c = 0; c < NCOEF; c++) active[s][c] <= shadow[s][c];
          end
`ifdef IIR_COEF_FLUSH_EN
          sec_flush <= dirty;
          dirty     <= '0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Active bank packed onto the cascade terminals, section s at bits [16s+15:16s]
  always_comb begin
    coef_b0 = '0;
    coef_b1 = '0;
    coef_b2 = '0;
    coef_a1 = '0;
    coef_a2 = '0;
    for (int s = 0; s < N_SEC; s++) begin
      coef_b0[16*s +: 16] = active[s][0];
      coef_b1[16*s +: 16] = active[s][1];
      coef_b2[16*s +: 16] = active[s][2];
      coef_a1[16*s +: 16] = active[s][3];
      coef_a2[16*s +: 16] = active[s][4];
    end
  end

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Self-checking bench for iir_coef_ctrl: directed scenarios plus randomized write/commit traffic
// checked against a bank-level reference model.
module tb_iir_coef_ctrl;

  localparam int unsigned N_SEC = 3;
  localparam int unsigned SEC_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic commit_req, commit_ack, commit_nak, sample_tick, err, err_clr, busy;
  logic [N_SEC*16-1:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
`ifdef IIR_COEF_FLUSH_EN
  logic [N_SEC-1:0] sec_flush;
`endif

  iir_coef_ctrl_if #(.SEC_W(SEC_W)) wr ();

  iir_coef_ctrl #(.N_SEC(N_SEC), .SEC_W(SEC_W), .B0_RST(16'sh4000)) dut (
    .clk(clk), .rst(rst), .wr(wr),
    .commit_req(commit_req), .commit_ack(commit_ack), .commit_nak(commit_nak),
    .sample_tick(sample_tick), .err(err), .err_clr(err_clr), .busy(busy),
    .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_b2(coef_b2),
    .coef_a1(coef_a1), .coef_a2(coef_a2)
`ifdef IIR_COEF_FLUSH_EN
    , .sec_flush(sec_flush)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [15:0] m_shadow [N_SEC][5];
  logic [15:0] m_active [N_SEC][5];
  logic        m_err;
  logic [N_SEC-1:0] m_dirty;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < N_SEC; s++)
      for (int c = 0; c < 5; c++) begin
        m_shadow[s][c] = (c == 0) ? 16'h4000 : 16'h0000;
        m_active[s][c] = (c == 0) ? 16'h4000 : 16'h0000;
      end
    m_err   = 1'b0;
    m_dirty = '0;
  endtask

  task automatic model_write(input int sec, input int idx, input logic [15:0] data, input bit clr);
    if (sec < N_SEC && idx <= 4) begin
      m_shadow[sec][idx] = data;
      m_dirty[sec] = 1'b1;
      if (clr) m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic chk_coefs(input string tag);
    logic [N_SEC*16-1:0] e [5];
    for (int c = 0; c < 5; c++) begin
      e[c] = '0;
      for (int s = 0; s < N_SEC; s++) e[c][16*s +: 16] = m_active[s][c];
    end
    chk({tag, "_b0"}, 64'(coef_b0), 64'(e[0]));
    chk({tag, "_b1"}, 64'(coef_b1), 64'(e[1]));
    chk({tag, "_b2"}, 64'(coef_b2), 64'(e[2]));
    chk({tag, "_a1"}, 64'(coef_a1), 64'(e[3]));
    chk({tag, "_a2"}, 64'(coef_a2), 64'(e[4]));
  endtask

  task automatic drive_wr(input int sec, input int idx, input logic [15:0] data);
    wr.wr_valid = 1'b1;
    wr.wr_sec   = SEC_W'(sec);
    wr.wr_idx   = 3'(idx);
    wr.wr_data  = data;
  endtask

  task automatic wr_one(input int sec, input int idx, input logic [15:0] data, input bit clr);
    chk("wr_ready_idle", 64'(wr.wr_ready), 64'd1);
    drive_wr(sec, idx, data);
    err_clr = clr;
    model_write(sec, idx, data, clr);
    step();
    wr.wr_valid = 1'b0;
    err_clr = 1'b0;
    chk("err_after_wr", 64'(err), 64'(m_err));
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_err = 1'b0;
    chk("err_cleared", 64'(err), 64'd0);
  endtask

  // Commit request (optionally with a same-cycle write), then a tick after 'delay' PEND cycles
  task automatic commit_seq(input bit with_wr, input int sec, input int idx,
                            input logic [15:0] data, input int delay);
    if (with_wr) begin
      drive_wr(sec, idx, data);
      model_write(sec, idx, data, 1'b0);
    end
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    wr.wr_valid = 1'b0;
    if (m_err) begin
      chk("nak_pulse", 64'(commit_nak), 64'd1);
      chk("nak_busy", 64'(busy), 64'd0);
      chk("nak_err", 64'(err), 64'd1);
      step();
      chk("nak_one_cycle", 64'(commit_nak), 64'd0);
      chk_coefs("nak_nochange");
      return;
    end
    chk("pend_busy", 64'(busy), 64'd1);
    chk("pend_wr_ready", 64'(wr.wr_ready), 64'd0);
    chk("pend_no_nak", 64'(commit_nak), 64'd0);
    repeat (delay) step();
    chk_coefs("pre_tick");
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("apply_no_ack", 64'(commit_ack), 64'd0);
    chk_coefs("tick_edge");
    step();
    for (int s = 0; s < N_SEC; s++)
      for (int c = 0; c < 5; c++) m_active[s][c] = m_shadow[s][c];
    chk("ack_pulse", 64'(commit_ack), 64'd1);
    chk("ack_busy", 64'(busy), 64'd1);
    chk_coefs("post_commit");
`ifdef IIR_COEF_FLUSH_EN
    chk("sec_flush", 64'(sec_flush), 64'(m_dirty));
`endif
    m_dirty = '0;
    step();
    chk("ack_one_cycle", 64'(commit_ack), 64'd0);
    chk("busy_drop", 64'(busy), 64'd0);
`ifdef IIR_COEF_FLUSH_EN
    chk("sec_flush_drop", 64'(sec_flush), 64'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    commit_req = 1'b0;
    sample_tick = 1'b0;
    err_clr = 1'b0;
    wr.wr_valid = 1'b0;
    wr.wr_sec = '0;
    wr.wr_idx = '0;
    wr.wr_data = '0;
    model_reset();

    // reset state
    repeat (3) step();
    chk("rst_wr_ready", 64'(wr.wr_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(commit_ack), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_wr_ready", 64'(wr.wr_ready), 64'd1);
    chk("post_rst_err", 64'(err), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_b0", 64'(coef_b0), 64'h0000_4000_4000_4000);
    chk_coefs("post_rst");

    // basic commit with 5-cycle tick wait
    wr_one(1, 3, 16'h1234, 1'b0);
    chk_coefs("shadow_invisible");
    commit_seq(1'b0, 0, 0, 16'h0, 5);
    chk("a1_sec1", 64'(coef_a1[31:16]), 64'h1234);

    // out-of-range section, nak, then clear and commit
    wr_one(3, 0, 16'h7777, 1'b0);
    commit_seq(1'b0, 0, 0, 16'h0, 0);
    clear_err();
    commit_seq(1'b0, 0, 0, 16'h0, 2);

    // error write wins over a same-cycle clear
    wr_one(0, 5, 16'h0001, 1'b1);
    chk("set_wins", 64'(err), 64'd1);
    clear_err();

    // same-cycle write and commit; then bad write with commit is refused
    commit_seq(1'b1, 2, 4, 16'hBEEF, 1);
    commit_seq(1'b1, 3, 1, 16'h5555, 0);
    clear_err();

    // commit_req with tick in the same cycle: that tick is not used
    wr_one(2, 1, 16'hA5A5, 1'b0);
    commit_req = 1'b1;
    sample_tick = 1'b1;
    step();
    commit_req = 1'b0;
    sample_tick = 1'b0;
    chk("same_tick_busy", 64'(busy), 64'd1);
    step();
    step();
    chk("same_tick_no_ack", 64'(commit_ack), 64'd0);
    chk_coefs("same_tick_old");
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk_coefs("same_tick_edge");
    step();
    for (int s = 0; s < N_SEC; s++)
      for (int c = 0; c < 5; c++) m_active[s][c] = m_shadow[s][c];
    m_dirty = '0;
    chk("same_tick_ack", 64'(commit_ack), 64'd1);
    chk_coefs("same_tick_new");
    step();

    // reset while pending discards the commit and the shadow bank
    wr_one(0, 2, 16'h0100, 1'b0);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    rst = 1'b1;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    step();
    chk("rst_pend_no_ack", 64'(commit_ack), 64'd0);
    chk("rst_pend_b2", 64'(coef_b2), 64'd0);
    chk("rst_pend_busy", 64'(busy), 64'd0);
    commit_seq(1'b0, 0, 0, 16'h0, 1);

`ifdef IIR_COEF_FLUSH_EN
    // only written sections are flushed
    wr_one(0, 0, 16'h1111, 1'b0);
    wr_one(2, 4, 16'h2222, 1'b0);
    commit_seq(1'b0, 0, 0, 16'h0, 0);
    commit_seq(1'b0, 0, 0, 16'h0, 0);
`endif

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      int n;
      n = int'($urandom_range(0, 3));
      for (int j = 0; j < n; j++)
        wr_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 16'($urandom),
               $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1)
        commit_seq(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 16'($urandom),
                   int'($urandom_range(0, 3)));
      else
        commit_seq(1'b0, 0, 0, 16'h0, int'($urandom_range(0, 3)));
      if (m_err && $urandom_range(0, 3) != 0) clear_err();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iir_coef_ctrl.md
# iir_coef_ctrl

Coefficient configuration controller for a cascade of N_SEC 16-bit biquad sections. It accepts coefficient writes into a shadow bank over a valid/ready port. On request, it commits the whole shadow bank to the active bank. The commit is atomic and aligned to a sample boundary, so no biquad ever computes a sample with a mix of old and new coefficients. It sits between the host/config interface and the biquad cascade and drives every section's b_0, b_1, b_2, a_1, a_2 terminals.

## Interface
- N_SEC, 3: number of biquad sections; 1..2^SEC_W.
- SEC_W, 2: width of wr_sec.
- B0_RST, 16'sh4000: reset value of every active and shadow b_0 (unity, Q2.14); all other coefficients reset to 0.

- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- wr_valid  in  1  coefficient write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_sec  in  SEC_W  target section.
- wr_idx  in  3  coefficient index: 0=b_0, 1=b_1, 2=b_2, 3=a_1, 4=a_2.
- wr_data  in  16  signed coefficient value.
- commit_req  in  1  one-cycle pulse requesting shadow→active commit.
- commit_ack  out  1  one-cycle pulse: active bank updated.
- commit_nak  out  1  one-cycle pulse: commit refused because err=1.
- sample_tick  in  1  one-cycle strobe; a new input sample enters the cascade this cycle.
- err  out  1  sticky; set by an out-of-range write.
- err_clr  in  1  clears err.
- busy  out  1  high in PEND or APPLY.
- coef_b0, coef_b1, coef_b2, coef_a1, coef_a2  out  N_SEC*16 each  active coefficients; section s occupies bits [16s+15:16s].
- sec_flush  out  N_SEC  per-section flush pulse. Present only with IIR_COEF_FLUSH_EN.

## Operation
- Storage: a shadow bank and an active bank, each N_SEC×5×16 bits. The dirty mask is N_SEC bits.
- States:
  - IDLE. wr_ready=1. A commit_req with err=0 → PEND. A commit_req with err=1 → commit_nak pulse next cycle; stay in IDLE.
  - PEND. wr_ready=0. On sample_tick → APPLY.
  - APPLY (one cycle). active←shadow for all sections, dirty←0, commit_ack pulse → IDLE.
- Writes:
  - Accepted write with wr_sec<N_SEC and wr_idx≤4: shadow[wr_sec][wr_idx]←wr_data, dirty[wr_sec]←1.
  - Out-of-range write: the handshake still completes, shadow is unchanged, err←1.
- Writes never touch the active bank directly. The coef_* outputs are driven straight from active registers, with no combinational path from inputs.
- Simultaneous events:
  - wr accept + commit_req in the same IDLE cycle: the write lands in shadow and is included in the commit. If that write is out of range, err is set in the same edge and the commit is refused (nak).
  - commit_req + sample_tick in the same IDLE cycle: that tick is not used; the commit waits for the next tick in PEND.
  - commit_req while busy: ignored; no ack, no nak.
  - err_clr + error write in the same cycle: err=1 (set wins).
- Reset (RST high on any edge, including mid-PEND/APPLY):
  - state=IDLE.
  - both banks → b_0=B0_RST, others 0.
  - dirty=0, err=0.
  - commit_ack=commit_nak=sec_flush=0, busy=0, wr_ready=0 during reset and 1 the first cycle after.
  - A pending commit is discarded.

## Timing
- Write latency: a shadow value is updated at the accepting edge. It is invisible on coef_* until commit.
- Commit latency: sample_tick sampled in PEND at edge k → APPLY during cycle k..k+1. The active bank and coef_* change at edge k+1. commit_ack is high for cycle k+1..k+2; busy drops at edge k+2.
- Coefficients change exactly once per commit, one clock after the tick edge. The cascade must register its input sample on sample_tick to see a consistent set for the next sample.
- Nak latency: commit_req at edge k → commit_nak high for cycle k..k+1 (registered, one cycle).
- Throughput: one write per cycle in IDLE. The minimum commit period is 3 cycles plus the wait for a tick.

## Configuration
- IIR_COEF_FLUSH_EN defined:
  - sec_flush[s] pulses high in the same cycle as commit_ack for each section with dirty[s]=1 at APPLY.
  - It is intended to OR into that biquad's RST to clear its delay state.
  - Clean sections keep their state.
- Undefined: the sec_flush port does not exist, and section delay state persists across commits.

## Test plan
- Reset → coef_b0 = {3{16'sh4000}}; all other coef_* = 0; err=0; busy=0; wr_ready=1 the cycle after RST falls.
- Write sec1/idx3=16'sh1234, commit_req, sample_tick 5 cycles later → coef_a1[31:16]=16'sh1234 exactly one edge after the tick; commit_ack one cycle wide; unchanged before the tick.
- Write sec3 (N_SEC=3) → err=1, shadow unchanged. Then commit_req → commit_nak pulse with no state change. Then err_clr, commit_req, tick → commit_ack.
- commit_req + sample_tick in the same cycle → no update at that tick; update one edge after the following tick.
- RST asserted in PEND after writing b_2=16'sh0100 → no commit_ack; coef_b2 stays 0; shadow is reset; a subsequent commit applies B0_RST/zeros.
- With IIR_COEF_FLUSH_EN: write sec0 and sec2 only, commit → sec_flush=3'b101 coincident with commit_ack; a second commit with no writes gives sec_flush=3'b000.
